// File: rtl/decode_dispatch_queue_pkg.sv
// Shared types for the decode/dispatch queue: the decoded micro-op bundle and its command encodings.
package dq_pkg;

  localparam int PC_W = 64;

  localparam logic [2:0] CT_ALU   = 3'd0;
  localparam logic [2:0] CT_STORE = 3'd1;
  localparam logic [2:0] CT_BCOND = 3'd3;
  localparam logic [2:0] CT_CBZ   = 3'd5;
  localparam logic [2:0] CT_BR    = 3'd6;
  localparam logic [2:0] CT_BL    = 3'd7;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [4:0]      regRD;
    logic            regWrite;
    logic            memWrite;
    logic            read_enable;
    logic            memToReg;
    logic            ALUSrc;
    logic [2:0]      ALUOp;
    logic [1:0]      whichMath;
    logic            leftShift;
    logic            mult;
    logic            div;
    logic            saveCond;
    logic            needToForward;
    logic            uncondBr;
    logic            brTaken;
    logic            BRMI;
    logic            valueToStore;
    logic            dOrImm;
    logic            reg2Loc;
    logic [2:0]      commandType;
  } uop_t;

  localparam int UOP_W = $bits(uop_t);

  // A register-indirect branch must not dispatch past in-flight ops.
  function automatic logic is_serialising(input uop_t u);
    return u.BRMI;
  endfunction

endpackage

// File: rtl/decode_dispatch_queue_ptr.sv
// Wrap-around queue pointer: increments modulo 2**W, clear has priority over increment.
module dq_ptr #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);

  logic [W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)      ptr_d = '0;
    else if (inc_i) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/decode_dispatch_queue.sv
// Elastic FIFO of decoded uops between decode and rename/dispatch, flushable on redirect.
// Optional same-cycle bypass of an empty queue when DQ_BYPASS_EN is defined.
module decode_dispatch_queue
  import dq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  uop_t                     in_uop,
  output logic                     in_ready,
  output logic                     out_valid,
  output uop_t                     out_uop,
  input  logic                     out_ready,
  input  logic                     flush,
  input  logic                     rob_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);

  uop_t             mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count_q, count_d;
  uop_t             head_uop;
  logic             q_valid, bypass, push, pop;

  assign head_uop = mem[head];
  assign in_ready = (count_q != FULL_C);
  assign q_valid  = (count_q != '0) & ~(is_serialising(head_uop) & ~rob_empty);

`ifdef DQ_BYPASS_EN
  assign bypass = (count_q == '0) & in_valid & out_ready & ~flush & ~is_serialising(in_uop);
`else
  assign bypass = 1'b0;
`endif

  // A bypassed uop never touches storage, so it is neither a push nor a pop.
  assign push = in_valid & in_ready & ~bypass;
  assign pop  = q_valid & out_ready;

  assign out_valid = q_valid | bypass;
  assign out_uop   = bypass ? in_uop : (q_valid ? head_uop : '0);
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (flush)            count_d = '0;
    else if (push & ~pop) count_d = count_q + 1'b1;
    else if (pop & ~push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= in_uop;
  end

  dq_ptr #(.W(PTR_W)) u_head (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .inc_i (pop),
    .ptr_o (head)
  );

  dq_ptr #(.W(PTR_W)) u_tail (
    .clk   (clk),
    .reset (reset),
    .clr_i (flush),
    .inc_i (push),
    .ptr_o (tail)
  );

  a_no_underflow: assert property (@(posedge clk) disable iff (reset) !(pop && count_q == '0));
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) !(push && count_q == FULL_C));

endmodule
